// File: rtl/detect_faces_mul_arbiter.sv
// Round-robin arbiter sharing one A_W x B_W unsigned multiplier among NUM_REQ
// requesters; single registered response slot with valid/ready backpressure.
module detect_faces_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 16,
  parameter int B_W     = 7,
  parameter int P_W     = 22
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  input  logic                   rsp_ready
);

  localparam int FULL_W = A_W + B_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [P_W-1:0]    rsp_data_q, rsp_data_d;

  logic              slot_free_s;
  logic              grant_any_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [A_W-1:0]    a_sel_s;
  logic [B_W-1:0]    b_sel_s;
  logic [P_W-1:0]    prod_s;

  assign slot_free_s = (state_q == ST_EMPTY) || rsp_ready;

  // Round-robin scan starting at rr_ptr; nothing is granted while in reset.
  always_comb begin
    logic [ID_W:0] idx_sum;
    grant_s     = '0;
    grant_id_s  = '0;
    grant_any_s = 1'b0;
    idx_sum     = '0;
    if (slot_free_s && !ap_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
        end else begin
          idx_sum = idx_sum;
        end
        if (!grant_any_s && req_valid[idx_sum[ID_W-1:0]]) begin
          grant_any_s                  = 1'b1;
          grant_s[idx_sum[ID_W-1:0]]   = 1'b1;
          grant_id_s                   = idx_sum[ID_W-1:0];
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // Operand mux and truncated product for the granted requester.
  always_comb begin
    a_sel_s = req_a[int'(grant_id_s)*A_W +: A_W];
    b_sel_s = req_b[int'(grant_id_s)*B_W +: B_W];
    prod_s  = P_W'(FULL_W'(a_sel_s) * FULL_W'(b_sel_s));
  end

  // Slot next-state: a grant always loads new data; otherwise drain on rsp_ready.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (grant_any_s) begin
      state_d    = ST_FULL;
      rsp_id_d   = grant_id_s;
      rsp_data_d = prod_s;
      if (grant_id_s == ID_W'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id_s + ID_W'(1);
      end
    end else begin
      case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_FULL:  state_d = rsp_ready ? ST_EMPTY : ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // State and response registers; reset discards any in-flight response.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_detect_faces_mul_arbiter.sv
// Self-checking bench for detect_faces_mul_arbiter: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_detect_faces_mul_arbiter;

  localparam int N = 4;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [63:0]  req_a = '0;
  logic [27:0]  req_b = '0;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [21:0]  rsp_data;
  logic         rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  detect_faces_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .A_W(16), .B_W(7), .P_W(22)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] a;
    logic [27:0] b;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [21:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [63:0] a, input logic [27:0] b,
                              input logic rdy, input logic [3:0] er, input logic ev,
                              input logic [1:0] eid, input logic [21:0] ed);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
    v.exp_ready = er; v.exp_valid = ev; v.exp_id = eid; v.exp_data = ed;
    return v;
  endfunction

  function automatic longint mprod(input longint a, input longint b);
    return (a * b) % 64'd4194304;
  endfunction

  task automatic do_reset();
    ap_rst = 1'b1;
    req_valid = '0;
    tick();
    ap_rst = 1'b0;
    #1;
  endtask

  // Behavioural model state for the random phase
  bit     m_valid;
  int     m_id;
  longint m_data;
  int     m_ptr;
  bit     pend[N];
  longint pa[N];
  longint pb[N];

  function automatic int model_grant(input logic [3:0] vld, input logic rdy);
    if (m_valid && !rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_pending();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i*16 +: 16] = 16'(pa[i]);
      req_b[i*7 +: 7] = 7'(pb[i]);
    end
  endtask

  initial begin
    int g;
    logic [3:0] exp_r;

    tbl[0] = mk(4'b0100, {16'd0, 16'd300, 16'd0, 16'd0}, {7'd0, 7'd5, 7'd0, 7'd0}, 1'b1, 4'b0100, 1'b1, 2'd2, 22'd1500);
    tbl[1] = mk(4'b0000, 64'd0, 28'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 22'd0);
    tbl[2] = mk(4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b1, 4'b1000, 1'b1, 2'd3, 22'd160);
    tbl[3] = mk(4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b1, 4'b0001, 1'b1, 2'd0, 22'd10);
    tbl[4] = mk(4'b0001, {16'd0, 16'd0, 16'd0, 16'd65535}, {7'd0, 7'd0, 7'd0, 7'd127}, 1'b1, 4'b0001, 1'b1, 2'd0, 22'h3EFF81);
    tbl[5] = mk(4'b0010, 64'd0, {7'd0, 7'd0, 7'd99, 7'd0}, 1'b1, 4'b0010, 1'b1, 2'd1, 22'd0);
    tbl[6] = mk(4'b0100, {16'd0, 16'd12345, 16'd0, 16'd0}, 28'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 22'd0);
    tbl[7] = mk(4'b0000, 64'd0, 28'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 22'd0);

    // Reset state
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    tick();
    ap_rst = 1'b0;

    // Vector table
    for (int r = 0; r < 8; r++) begin
      req_valid = tbl[r].vld; req_a = tbl[r].a; req_b = tbl[r].b; rsp_ready = tbl[r].rdy;
      @(negedge ap_clk);
      chk($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].exp_ready);
      tick();
      chk($sformatf("tbl%0d_rsp_valid", r), rsp_valid, tbl[r].exp_valid);
      if (tbl[r].exp_valid) begin
        chk($sformatf("tbl%0d_rsp_id", r), rsp_id, tbl[r].exp_id);
        chk($sformatf("tbl%0d_rsp_data", r), rsp_data, tbl[r].exp_data);
      end
    end

    // Asynchronous reset while a response is held
    do_reset();
    req_valid = 4'b0001; req_a = 64'd5; req_b = 28'd5; rsp_ready = 1'b0;
    tick();
    chk("arst_pre_valid", rsp_valid, 1);
    chk("arst_pre_data", rsp_data, 25);
    req_valid = 4'b1111;
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_req_ready", req_ready, 0);
    #1 ap_rst = 1'b0;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    chk("arst_ptr_restart", req_ready, 4'b0100);
    tick();

    // Round robin with a continuously valid set of requesters
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = {16'd7, 16'd300, 16'd42, 16'd100};
    req_b = {7'd127, 7'd5, 7'd1, 7'd3};
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      chk($sformatf("rr%0d_grant", c), req_ready, 4'b0001 << (c % 4));
      tick();
      chk($sformatf("rr%0d_valid", c), rsp_valid, 1);
      chk($sformatf("rr%0d_id", c), rsp_id, c % 4);
      chk($sformatf("rr%0d_data", c), rsp_data, mprod(longint'(req_a[(c%4)*16 +: 16]), longint'(req_b[(c%4)*7 +: 7])));
    end

    // Backpressure holds the slot (id 1, data 42)
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk($sformatf("bp%0d_req_ready", c), req_ready, 0);
      chk($sformatf("bp%0d_valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d_id", c), rsp_id, 1);
      chk($sformatf("bp%0d_data", c), rsp_data, 42);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b0100);
    tick();
    chk("bp_release_id", rsp_id, 2);
    chk("bp_release_data", rsp_data, 1500);

    // Pointer skip: grant 0, then 3 ahead of 0, then 0
    req_valid = 4'b0001;
    @(negedge ap_clk);
    chk("skip_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1001;
    @(negedge ap_clk);
    chk("skip_grant3", req_ready, 4'b1000);
    tick();
    chk("skip_id3", rsp_id, 3);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    chk("skip_grant0_again", req_ready, 4'b0001);
    tick();
    chk("skip_id0", rsp_id, 0);

    // Randomized run against the behavioural model
    do_reset();
    m_valid = 1'b0; m_id = 0; m_data = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = 0; pb[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      drive_pending();
      @(negedge ap_clk);
      g = model_grant(req_valid, rsp_ready);
      exp_r = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rnd_req_ready", req_ready, exp_r);
      chk("rnd_rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rnd_rsp_id", rsp_id, m_id);
        chk("rnd_rsp_data", rsp_data, m_data);
      end
      @(posedge ap_clk);
      if (g >= 0) begin
        m_valid = 1'b1; m_id = g; m_data = mprod(pa[g], pb[g]);
        m_ptr = (g + 1) % N; pend[g] = 1'b0;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 5))
            0: begin pa[i] = 65535; pb[i] = 127; end
            1: begin pa[i] = 0; pb[i] = longint'($urandom_range(0, 127)); end
            default: begin pa[i] = longint'($urandom_range(0, 65535)); pb[i] = longint'($urandom_range(0, 127)); end
          endcase
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_faces_mul_arbiter.md
Name: detect_faces_mul_arbiter

Overview:
- Shares one unsigned 16-bit x 7-bit multiplier (22-bit truncated product) among NUM_REQ requesters in the face-detection datapath, e.g. the feature-weight scaling and window-variance stages.
- Grants are round-robin. The block has one registered output slot, so latency is one cycle.
- Responses return on a single shared bus tagged with the requester index, with valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal max(1, ceil(log2(NUM_REQ))).
- A_W, 16, operand A width (unsigned).
- B_W, 7, operand B width (unsigned).
- P_W, 22, product width; the product is truncated to its low P_W bits.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents an operand pair.
- req_a  in  NUM_REQ*A_W  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*B_W  operand B; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot or zero; bit i: requester i's pair is accepted this cycle.
- rsp_valid  out  1  rsp_data and rsp_id are valid.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  P_W  product (req_a x req_b) mod 2^P_W.
- rsp_ready  in  1  consumer takes the response this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0.
  - req_ready is forced to all zeros while ap_rst=1.
  - An in-flight response is discarded.
- slot_free = !rsp_valid || rsp_ready (combinational).
- Grant (combinational):
  - If slot_free, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = that one-hot grant; otherwise req_ready=0.
  - Requesters must not make req_valid depend on req_ready.
  - Once raised, req_valid and the operands must stay stable until accepted.
- Accept (req_valid[i] && req_ready[i]) at edge t:
  - At t+1: rsp_valid=1, rsp_id=i, rsp_data=low P_W bits of zero-extended req_a[i] x req_b[i].
  - rr_ptr = (i+1) mod NUM_REQ.
- No accept at edge t:
  - rr_ptr unchanged.
  - If rsp_ready=1, rsp_valid drops to 0.
  - rsp_data and rsp_id keep their last values; they are don't-care while rsp_valid=0.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_valid, rsp_id and rsp_data are held.
  - req_ready=0.
- Simultaneous drain and accept: when rsp_valid=1, rsp_ready=1 and a request is granted in the same cycle, the new response replaces the old one with no bubble. Sustained throughput is 1 product per cycle.
- Fairness: with all requesters continuously valid and rsp_ready=1, the grant order is 0,1,...,NUM_REQ-1,0,...
- Arithmetic:
  - Unsigned only. The maximum full product is 65535 x 127 = 8322945 (needs 23 bits).
  - The result wraps modulo 2^22.
  - The multiply is computed combinationally from the granted slice and captured in the output register.

State machine (implicit in rsp_valid):
- EMPTY (rsp_valid=0):
  - any grant -> FULL
  - otherwise stay.
- FULL (rsp_valid=1):
  - rsp_ready=1 with a grant -> FULL (new data)
  - rsp_ready=1 with no grant -> EMPTY
  - rsp_ready=0 -> FULL (held).

Test Plan:
- Reset: raise ap_rst asynchronously between edges while rsp_valid=1 -> rsp_valid=0, rsp_data=0 and req_ready=0 immediately. After release, only req_valid[2]=1 -> grant goes to 2 (the pointer restarted at 0).
- Single request: req_valid=4'b0100, a[2]=300, b[2]=5, rsp_ready=1 -> req_ready=4'b0100 in the same cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_data=1500; the following cycle rsp_valid=0.
- Round robin: req_valid=4'b1111 held, distinct operands, rsp_ready=1 -> grants on successive cycles are 0,1,2,3,0,1. rsp_id follows one cycle later with the correct products and no idle cycles.
- Backpressure:
  - rsp_valid=1 (id=1, data=42), hold rsp_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 and outputs unchanged.
  - Raise rsp_ready -> in the same cycle req_ready=4'b0100 (pointer at 2), and next cycle rsp_id=2.
- Wrap/truncation: a=65535, b=127 -> rsp_data=22'h3EFF81 (4128641). With a=0 or b=0 -> rsp_data=0.
- Pointer skip: grant requester 0 (rr_ptr becomes 1), then req_valid=4'b1001 -> requester 3 is granted first. On the following cycle, with requester 0 still valid, requester 0 is granted.
